// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch stage.
// Drives the fetch address and chip enable, with branch/flush redirects.
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INST_BYTES   = 4,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending_o,
    output logic               misaligned_o
);

    localparam int ALIGN_W = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

    typedef enum logic {
        S_OFF,
        S_RUN
    } state_t;

    state_t            state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              fetch_stall;

    assign fetch_stall        = stall[0];
    assign redirect_pending_o = pend_valid;

    // Upper stall bits belong to later stages and are not consumed here.
    generate
        if (STALL_W > 1) begin : g_stall_sink
            logic unused_stall;
            assign unused_stall = ^stall[STALL_W-1:1];
        end
    endgenerate

    // Misalignment flag for the exception unit; byte-wide fetch is never misaligned.
    generate
        if (ALIGN_W > 0) begin : g_align
            assign misaligned_o = |pc[ALIGN_W-1:0];
        end else begin : g_no_align
            assign misaligned_o = 1'b0;
        end
    endgenerate

    // Boot sequencing and prioritized next-pc selection; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            ce          <= 1'b0;
            pc          <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    // First fetch after release is the reset vector itself.
                    state       <= S_RUN;
                    ce          <= 1'b1;
                    pc          <= RESET_VECTOR;
                    pend_valid  <= 1'b0;
                    pend_target <= '0;
                end
                S_RUN: begin
                    ce <= 1'b1;
                    if (flush_i) begin
                        // Exceptions win even over a stall; any branch is dropped.
                        pc         <= new_pc_i;
                        pend_valid <= 1'b0;
                    end else if (branch_flag_i && !fetch_stall) begin
                        pc         <= branch_target_address_i;
                        pend_valid <= 1'b0;
                    end else if (branch_flag_i) begin
                        // Park the target until fetch can move; newest wins.
                        pend_valid  <= 1'b1;
                        pend_target <= branch_target_address_i;
                    end else if (pend_valid && !fetch_stall) begin
                        pc         <= pend_target;
                        pend_valid <= 1'b0;
                    end else if (!fetch_stall) begin
                        pc <= pc + STEP;
                    end
                end
                default: begin
                    state <= S_OFF;
                    ce    <= 1'b0;
                    pc    <= RESET_VECTOR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expectations,
// a monitor pops and compares after each clock edge.
module tb_pc_gen;

    localparam int ADDR_W  = 32;
    localparam int STALL_W = 6;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        pend;
        logic        mis;
        string       name;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [STALL_W-1:0] stall = '0;
    logic               branch_flag_i = 1'b0;
    logic [ADDR_W-1:0]  branch_target_address_i = '0;
    logic               flush_i = 1'b0;
    logic [ADDR_W-1:0]  new_pc_i = '0;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending_o;
    logic               misaligned_o;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;

    pc_gen #(
        .ADDR_W(ADDR_W),
        .RESET_VECTOR(RV),
        .INST_BYTES(4),
        .STALL_W(STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .flush_i(flush_i),
        .new_pc_i(new_pc_i),
        .pc(pc),
        .ce(ce),
        .redirect_pending_o(redirect_pending_o),
        .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the
    // expected outputs for just after the following rising edge.
    task automatic step(
        input string       name,
        input logic        r,
        input logic [5:0]  st,
        input logic        br,
        input logic [31:0] bt,
        input logic        fl,
        input logic [31:0] np,
        input logic        e_ce,
        input logic [31:0] e_pc,
        input logic        e_pend,
        input logic        e_mis
    );
        exp_t e;
        @(negedge clk);
        rst = r;
        stall = st;
        branch_flag_i = br;
        branch_target_address_i = bt;
        flush_i = fl;
        new_pc_i = np;
        e.ce = e_ce;
        e.pc = e_pc;
        e.pend = e_pend;
        e.mis = e_mis;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                applied++;
                if (ce !== e.ce || pc !== e.pc ||
                    redirect_pending_o !== e.pend ||
                    misaligned_o !== e.mis) begin
                    miscompares++;
                    $display("FAIL %s: got ce=%b pc=%h pend=%b mis=%b, want ce=%b pc=%h pend=%b mis=%b",
                             e.name, ce, pc, redirect_pending_o, misaligned_o,
                             e.ce, e.pc, e.pend, e.mis);
                end
            end
        end
    end

    initial begin
        int budget;
        // Reset held three cycles
        step("rst0", 1, 6'h00, 0, 0, 0, 0, 0, RV, 0, 0);
        step("rst1", 1, 6'h00, 0, 0, 0, 0, 0, RV, 0, 0);
        step("rst2", 1, 6'h00, 0, 0, 0, 0, 0, RV, 0, 0);
        step("boot", 0, 6'h00, 0, 0, 0, 0, 1, RV, 0, 0);
        step("seq1", 0, 6'h00, 0, 0, 0, 0, 1, 32'hBFC0_0004, 0, 0);
        step("seq2", 0, 6'h00, 0, 0, 0, 0, 1, 32'hBFC0_0008, 0, 0);
        // Stall hold at 0x100
        step("br100", 0, 6'h00, 1, 32'h100, 0, 0, 1, 32'h100, 0, 0);
        step("stl1", 0, 6'h01, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        step("stl2", 0, 6'h01, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        step("rel", 0, 6'h00, 0, 0, 0, 0, 1, 32'h104, 0, 0);
        step("hiSt1", 0, 6'b111110, 0, 0, 0, 0, 1, 32'h108, 0, 0);
        step("hiSt2", 0, 6'b111110, 0, 0, 0, 0, 1, 32'h10C, 0, 0);
        // Plain branch
        step("fl20", 0, 6'h00, 0, 0, 1, 32'h20, 1, 32'h20, 0, 0);
        step("br400", 0, 6'h00, 1, 32'h400, 0, 0, 1, 32'h400, 0, 0);
        step("seq404", 0, 6'h00, 0, 0, 0, 0, 1, 32'h404, 0, 0);
        // Branches during stall, newest wins
        step("br40", 0, 6'h00, 1, 32'h40, 0, 0, 1, 32'h40, 0, 0);
        step("pb800", 0, 6'h01, 1, 32'h800, 0, 0, 1, 32'h40, 1, 0);
        step("pb900", 0, 6'h01, 1, 32'h900, 0, 0, 1, 32'h40, 1, 0);
        step("pwait", 0, 6'h01, 0, 0, 0, 0, 1, 32'h40, 1, 0);
        step("pfire", 0, 6'h00, 0, 0, 0, 0, 1, 32'h900, 0, 0);
        step("seq904", 0, 6'h00, 0, 0, 0, 0, 1, 32'h904, 0, 0);
        // Flush beats branch, stall and pending
        step("pb500", 0, 6'h01, 1, 32'h500, 0, 0, 1, 32'h904, 1, 0);
        step("flush", 0, 6'h01, 1, 32'h500, 1, 32'h180, 1, 32'h180, 0, 0);
        step("fhold", 0, 6'h01, 0, 0, 0, 0, 1, 32'h180, 0, 0);
        step("f184", 0, 6'h00, 0, 0, 0, 0, 1, 32'h184, 0, 0);
        // Wrap-around
        step("brTop", 0, 6'h00, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step("wrap", 0, 6'h00, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        // Misaligned target
        step("br102", 0, 6'h00, 1, 32'h102, 0, 0, 1, 32'h102, 0, 1);
        step("seq106", 0, 6'h00, 0, 0, 0, 0, 1, 32'h106, 0, 1);
        // Unstalled branch supersedes a parked target
        step("pb700", 0, 6'h01, 1, 32'h700, 0, 0, 1, 32'h106, 1, 1);
        step("br200", 0, 6'h00, 1, 32'h200, 0, 0, 1, 32'h200, 0, 0);
        step("seq204", 0, 6'h00, 0, 0, 0, 0, 1, 32'h204, 0, 0);
        // Reset while pending; redirects ignored on the boot edge
        step("pb300", 0, 6'h01, 1, 32'h300, 0, 0, 1, 32'h204, 1, 0);
        step("rstP", 1, 6'h00, 0, 0, 0, 0, 0, RV, 0, 0);
        step("bootIg", 0, 6'h00, 1, 32'h600, 1, 32'h999, 1, RV, 0, 0);
        step("seqRV4", 0, 6'h00, 0, 0, 0, 0, 1, 32'hBFC0_0004, 0, 0);
        @(negedge clk);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
